// File: rtl/udp_rx_port_demux.sv
// UDP rx frame filter/demux: one port/IP decision per frame, DELAY-cycle byte pipeline,
// one-hot channel valid with SOF/EOF markers, saturating accepted/dropped frame counters.
module udp_rx_port_demux #(
  parameter int unsigned             NUM_PORTS = 2,
  parameter int unsigned             DELAY     = 5,
  parameter logic [16*NUM_PORTS-1:0] PORT_LIST = {16'h2777, 16'h1777},
  parameter int unsigned             CNT_W     = 16
) (
  input  logic                       udp_rx_clk,
  input  logic                       rstn,
  input  logic [7:0]                 udp_rxd,
  input  logic                       udp_rx_dv,
  input  logic [15:0]                udp_rx_dst_port,
  input  logic [31:0]                udp_rx_src_ip,
  input  logic [NUM_PORTS-1:0]       cfg_port_en,
  input  logic                       cfg_ip_filt_en,
  input  logic [31:0]                cfg_ip_addr,
  input  logic [31:0]                cfg_ip_mask,
  input  logic                       cnt_clr,
  output logic [7:0]                 out_data,
  output logic [NUM_PORTS-1:0]       out_dv,
  output logic                       out_sof,
  output logic                       out_eof,
  output logic [15:0]                out_dst_port,
  output logic [31:0]                out_src_ip,
  output logic [NUM_PORTS*CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0]           drop_cnt
);

  localparam int unsigned CH_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned NS   = DELAY - 1;

  typedef enum logic [1:0] {S_WAIT_GAP, S_IDLE, S_PASS, S_DROP} state_t;

  state_t            r_state;
  logic [CH_W-1:0]   r_ch;

  logic [7:0]        r_pd [NS];
  logic [NS-1:0]     r_pv;
  logic [NS-1:0]     r_pf;
  logic [CH_W-1:0]   r_pc [NS];
  logic [15:0]       r_pp [NS];
  logic [31:0]       r_pi [NS];

  logic [7:0]           r_out_data;
  logic [NUM_PORTS-1:0] r_out_dv;
  logic                 r_out_sof;
  logic                 r_out_eof;
  logic [15:0]          r_out_port;
  logic [31:0]          r_out_ip;
  logic [CNT_W-1:0]     r_frame_cnt [NUM_PORTS];
  logic [CNT_W-1:0]     r_drop_cnt;

  logic              w_hit;
  logic [CH_W-1:0]   w_ch;
  logic              w_ip_ok;
  logic              w_start;
  logic              w_accept;
  logic              w_in_v;
  logic              w_in_f;
  logic [CH_W-1:0]   w_in_c;
  logic              w_nxt_v;
  logic              w_last_sof;

  // Port match; descending scan so the lowest matching channel wins
  always_comb begin
    w_hit = 1'b0;
    w_ch  = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (cfg_port_en[i] && (udp_rx_dst_port == PORT_LIST[16*i +: 16])) begin
        w_hit = 1'b1;
        w_ch  = CH_W'(i);
      end
    end
  end

  assign w_ip_ok  = !cfg_ip_filt_en ||
                    (((udp_rx_src_ip ^ cfg_ip_addr) & cfg_ip_mask) == 32'h0);
  assign w_start  = (r_state == S_IDLE) && udp_rx_dv;
  assign w_accept = w_hit && w_ip_ok;

  // Stage-0 tag: the first byte uses this cycle's evaluation, later bytes the held one
  assign w_in_v = (w_start && w_accept) || ((r_state == S_PASS) && udp_rx_dv);
  assign w_in_f = w_start && w_accept;
  assign w_in_c = w_start ? w_ch : r_ch;

  // Validity of the byte that will follow the one entering the output register
  generate
    if (NS >= 2) begin : g_nxt_stage
      assign w_nxt_v = r_pv[NS-2];
    end else begin : g_nxt_input
      assign w_nxt_v = w_in_v;
    end
  endgenerate

  assign w_last_sof = r_pv[NS-1] && r_pf[NS-1];

  // Frame decision FSM
  always_ff @(posedge udp_rx_clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_WAIT_GAP;
      r_ch    <= '0;
    end else begin
      case (r_state)
        S_WAIT_GAP: if (!udp_rx_dv) r_state <= S_IDLE;
        S_IDLE: begin
          if (udp_rx_dv) begin
            if (w_accept) begin
              r_state <= S_PASS;
              r_ch    <= w_ch;
            end else begin
              r_state <= S_DROP;
            end
          end
        end
        S_PASS, S_DROP: if (!udp_rx_dv) r_state <= S_IDLE;
        default: r_state <= S_WAIT_GAP;
      endcase
    end
  end

  // Byte/tag delay line; data always shifts, dropped bytes carry valid=0
  always_ff @(posedge udp_rx_clk or negedge rstn) begin
    if (!rstn) begin
      r_pv <= '0;
      r_pf <= '0;
      for (int k = 0; k < NS; k++) begin
        r_pd[k] <= '0;
        r_pc[k] <= '0;
        r_pp[k] <= '0;
        r_pi[k] <= '0;
      end
    end else begin
      r_pd[0] <= udp_rxd;
      r_pv[0] <= w_in_v;
      r_pf[0] <= w_in_f;
      r_pc[0] <= w_in_c;
      r_pp[0] <= udp_rx_dst_port;
      r_pi[0] <= udp_rx_src_ip;
      for (int k = 1; k < NS; k++) begin
        r_pd[k] <= r_pd[k-1];
        r_pv[k] <= r_pv[k-1];
        r_pf[k] <= r_pf[k-1];
        r_pc[k] <= r_pc[k-1];
        r_pp[k] <= r_pp[k-1];
        r_pi[k] <= r_pi[k-1];
      end
    end
  end

  // Output stage: one-hot decode, SOF/EOF, frame header latched with SOF
  always_ff @(posedge udp_rx_clk or negedge rstn) begin
    if (!rstn) begin
      r_out_data <= '0;
      r_out_dv   <= '0;
      r_out_sof  <= 1'b0;
      r_out_eof  <= 1'b0;
      r_out_port <= '0;
      r_out_ip   <= '0;
    end else begin
      r_out_data <= r_pd[NS-1];
      r_out_dv   <= r_pv[NS-1] ? (NUM_PORTS'(1) << r_pc[NS-1]) : '0;
      r_out_sof  <= w_last_sof;
      r_out_eof  <= r_pv[NS-1] && !w_nxt_v;
      if (w_last_sof) begin
        r_out_port <= r_pp[NS-1];
        r_out_ip   <= r_pi[NS-1];
      end
    end
  end

  // Saturating counters; clear wins over a coincident increment
  always_ff @(posedge udp_rx_clk or negedge rstn) begin
    if (!rstn) begin
      r_drop_cnt <= '0;
      for (int i = 0; i < NUM_PORTS; i++) r_frame_cnt[i] <= '0;
    end else if (cnt_clr) begin
      r_drop_cnt <= '0;
      for (int i = 0; i < NUM_PORTS; i++) r_frame_cnt[i] <= '0;
    end else begin
      if (w_start && !w_accept && (r_drop_cnt != '1))
        r_drop_cnt <= r_drop_cnt + CNT_W'(1);
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (w_last_sof && (r_pc[NS-1] == CH_W'(i)) && (r_frame_cnt[i] != '1))
          r_frame_cnt[i] <= r_frame_cnt[i] + CNT_W'(1);
      end
    end
  end

  generate
    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_cnt_out
      assign frame_cnt[g*CNT_W +: CNT_W] = r_frame_cnt[g];
    end
  endgenerate

  assign out_data     = r_out_data;
  assign out_dv       = r_out_dv;
  assign out_sof      = r_out_sof;
  assign out_eof      = r_out_eof;
  assign out_dst_port = r_out_port;
  assign out_src_ip   = r_out_ip;
  assign drop_cnt     = r_drop_cnt;

endmodule

// File: tb/tb_udp_rx_port_demux.sv
// Directed bench for udp_rx_port_demux: scheduled frames with hand-derived output timing,
// plus a narrow-counter instance for saturation and clear-priority checks.
module tb_udp_rx_port_demux;

  localparam int DLY = 5;
  localparam int NC  = 32;

  logic        clk;
  logic        rstn;
  logic [7:0]  udp_rxd;
  logic        udp_rx_dv;
  logic [15:0] udp_rx_dst_port;
  logic [31:0] udp_rx_src_ip;
  logic [1:0]  cfg_port_en;
  logic        cfg_ip_filt_en;
  logic [31:0] cfg_ip_addr;
  logic [31:0] cfg_ip_mask;
  logic        cnt_clr;

  logic [7:0]  out_data;
  logic [1:0]  out_dv;
  logic        out_sof;
  logic        out_eof;
  logic [15:0] out_dst_port;
  logic [31:0] out_src_ip;
  logic [31:0] frame_cnt;
  logic [15:0] drop_cnt;

  logic [7:0]  s_data;
  logic [1:0]  s_dv;
  logic        s_sof;
  logic        s_eof;
  logic [15:0] s_port;
  logic [31:0] s_ip;
  logic [7:0]  s_frame_cnt;
  logic [3:0]  s_drop_cnt;

  int n_assert;
  int n_fail;

  // Per-cycle stimulus and expected outputs for one scheduled run
  logic        st_rst  [NC];
  logic        st_dv   [NC];
  logic [7:0]  st_d    [NC];
  logic [15:0] st_port [NC];
  logic [31:0] st_ip   [NC];
  logic [1:0]  ex_dv   [NC];
  logic        ex_sof  [NC];
  logic        ex_eof  [NC];
  logic [7:0]  ex_d    [NC];

  udp_rx_port_demux #(.NUM_PORTS(2), .DELAY(DLY), .PORT_LIST({16'h2777, 16'h1777}), .CNT_W(16)) dut (
    .udp_rx_clk(clk), .rstn(rstn), .udp_rxd(udp_rxd), .udp_rx_dv(udp_rx_dv),
    .udp_rx_dst_port(udp_rx_dst_port), .udp_rx_src_ip(udp_rx_src_ip),
    .cfg_port_en(cfg_port_en), .cfg_ip_filt_en(cfg_ip_filt_en),
    .cfg_ip_addr(cfg_ip_addr), .cfg_ip_mask(cfg_ip_mask), .cnt_clr(cnt_clr),
    .out_data(out_data), .out_dv(out_dv), .out_sof(out_sof), .out_eof(out_eof),
    .out_dst_port(out_dst_port), .out_src_ip(out_src_ip),
    .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
  );

  udp_rx_port_demux #(.NUM_PORTS(2), .DELAY(DLY), .PORT_LIST({16'h2777, 16'h1777}), .CNT_W(4)) u_sat (
    .udp_rx_clk(clk), .rstn(rstn), .udp_rxd(udp_rxd), .udp_rx_dv(udp_rx_dv),
    .udp_rx_dst_port(udp_rx_dst_port), .udp_rx_src_ip(udp_rx_src_ip),
    .cfg_port_en(cfg_port_en), .cfg_ip_filt_en(cfg_ip_filt_en),
    .cfg_ip_addr(cfg_ip_addr), .cfg_ip_mask(cfg_ip_mask), .cnt_clr(cnt_clr),
    .out_data(s_data), .out_dv(s_dv), .out_sof(s_sof), .out_eof(s_eof),
    .out_dst_port(s_port), .out_src_ip(s_ip),
    .frame_cnt(s_frame_cnt), .drop_cnt(s_drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_sched();
    for (int c = 0; c < NC; c++) begin
      st_rst[c] = 1'b1; st_dv[c] = 1'b0; st_d[c] = 8'h00; st_port[c] = 16'h0; st_ip[c] = 32'h0;
      ex_dv[c] = 2'b00; ex_sof[c] = 1'b0; ex_eof[c] = 1'b0; ex_d[c] = 8'h00;
    end
  endtask

  // Input at cycle c is expected on the outputs at cycle c+DLY
  task automatic add_frame(input int start, input int len, input logic [15:0] port,
                           input logic [31:0] ip, input logic [1:0] onehot);
    for (int i = 0; i < len; i++) begin
      st_dv[start+i]   = 1'b1;
      st_d[start+i]    = 8'((start + i) * 13 + 5);
      st_port[start+i] = port;
      st_ip[start+i]   = ip;
      if (onehot != 2'b00) begin
        ex_dv[start+i+DLY] = onehot;
        ex_d[start+i+DLY]  = st_d[start+i];
      end
    end
    if (onehot != 2'b00) begin
      ex_sof[start+DLY]       = 1'b1;
      ex_eof[start+len-1+DLY] = 1'b1;
    end
  endtask

  task automatic run_sched(input string name, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      rstn            = st_rst[c];
      udp_rx_dv       = st_dv[c];
      udp_rxd         = st_d[c];
      udp_rx_dst_port = st_port[c];
      udp_rx_src_ip   = st_ip[c];
      #1;
      chk($sformatf("%s dv c%0d", name, c), 64'(out_dv), 64'(ex_dv[c]));
      chk($sformatf("%s sof c%0d", name, c), 64'(out_sof), 64'(ex_sof[c]));
      chk($sformatf("%s eof c%0d", name, c), 64'(out_eof), 64'(ex_eof[c]));
      if (ex_dv[c] != 2'b00)
        chk($sformatf("%s data c%0d", name, c), 64'(out_data), 64'(ex_d[c]));
      if (ex_sof[c]) begin
        chk($sformatf("%s port c%0d", name, c), 64'(out_dst_port), 64'(st_port[c-DLY]));
        chk($sformatf("%s ip c%0d", name, c), 64'(out_src_ip), 64'(st_ip[c-DLY]));
      end
      tick();
    end
    rstn = 1'b1;
  endtask

  initial begin
    n_assert = 0; n_fail = 0;
    rstn = 1'b0; udp_rxd = 8'h00; udp_rx_dv = 1'b0; udp_rx_dst_port = 16'h0; udp_rx_src_ip = 32'h0;
    cfg_port_en = 2'b11; cfg_ip_filt_en = 1'b0;
    cfg_ip_addr = 32'h0AA0_2400; cfg_ip_mask = 32'hFFFF_FF00; cnt_clr = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst out_dv", 64'(out_dv), 64'h0);
    chk("rst out_sof", 64'(out_sof), 64'h0);
    chk("rst out_eof", 64'(out_eof), 64'h0);
    chk("rst out_data", 64'(out_data), 64'h0);
    chk("rst out_dst_port", 64'(out_dst_port), 64'h0);
    chk("rst out_src_ip", 64'(out_src_ip), 64'h0);
    chk("rst frame_cnt", 64'(frame_cnt), 64'h0);
    chk("rst drop_cnt", 64'(drop_cnt), 64'h0);
    rstn = 1'b1;
    tick();

    // 10-byte frame to ch1
    clear_sched();
    add_frame(2, 10, 16'h2777, 32'hC0A8_0001, 2'b10);
    run_sched("s1", 19);
    chk("s1 frame_cnt", 64'(frame_cnt), 64'h0001_0000);
    chk("s1 drop_cnt", 64'(drop_cnt), 64'h0);

    // Unknown port, then a disabled channel
    clear_sched();
    add_frame(1, 4, 16'h3000, 32'hC0A8_0001, 2'b00);
    run_sched("s2a", 12);
    chk("s2a drop_cnt", 64'(drop_cnt), 64'd1);
    cfg_port_en = 2'b10;
    clear_sched();
    add_frame(1, 3, 16'h1777, 32'hC0A8_0001, 2'b00);
    run_sched("s2b", 11);
    chk("s2b drop_cnt", 64'(drop_cnt), 64'd2);
    chk("s2b frame_cnt", 64'(frame_cnt), 64'h0001_0000);
    cfg_port_en = 2'b11;

    // Source-IP filter: in-subnet accepted, out-of-subnet dropped
    cfg_ip_filt_en = 1'b1;
    clear_sched();
    add_frame(1, 3, 16'h1777, 32'h0AA0_2425, 2'b01);
    add_frame(5, 3, 16'h1777, 32'h0AA0_2505, 2'b00);
    run_sched("s3", 15);
    chk("s3 frame_cnt", 64'(frame_cnt), 64'h0001_0001);
    chk("s3 drop_cnt", 64'(drop_cnt), 64'd3);
    cfg_ip_filt_en = 1'b0;

    // Mid-frame port change, 1-cycle gaps, single-byte frames
    clear_sched();
    add_frame(1, 6, 16'h1777, 32'hC0A8_0002, 2'b01);
    for (int c = 4; c <= 6; c++) st_port[c] = 16'h2777;
    add_frame(8, 4, 16'h2777, 32'hC0A8_0003, 2'b10);
    add_frame(13, 1, 16'h2777, 32'hC0A8_0004, 2'b10);
    add_frame(15, 1, 16'h1777, 32'hC0A8_0005, 2'b01);
    run_sched("s4", 23);
    chk("s4 frame_cnt", 64'(frame_cnt), 64'h0003_0003);
    chk("s4 drop_cnt", 64'(drop_cnt), 64'd3);
    chk("s4 held port", 64'(out_dst_port), 64'h1777);
    chk("s4 held ip", 64'(out_src_ip), 64'hC0A8_0005);

    // Reset during bytes 4..5 of a 10-byte frame, then a normal frame
    clear_sched();
    add_frame(1, 10, 16'h1777, 32'hC0A8_0006, 2'b00);
    st_rst[5] = 1'b0;
    st_rst[6] = 1'b0;
    add_frame(13, 3, 16'h2777, 32'hC0A8_0007, 2'b10);
    run_sched("s5", 23);
    chk("s5 frame_cnt", 64'(frame_cnt), 64'h0001_0000);
    chk("s5 drop_cnt", 64'(drop_cnt), 64'h0);

    // Saturation on the 4-bit instance, then clear against a coincident drop
    for (int n = 0; n < 20; n++) begin
      udp_rx_dv = 1'b1; udp_rx_dst_port = 16'h3000; udp_rxd = 8'(n);
      tick();
      udp_rx_dv = 1'b0;
      tick();
    end
    chk("s6 drop_cnt", 64'(drop_cnt), 64'd20);
    chk("s6 sat drop_cnt", 64'(s_drop_cnt), 64'hF);
    chk("s6 sat frame_cnt", 64'(s_frame_cnt), 64'h10);
    udp_rx_dv = 1'b1; udp_rx_dst_port = 16'h3000; cnt_clr = 1'b1;
    tick();
    chk("s6 clr drop_cnt", 64'(drop_cnt), 64'h0);
    chk("s6 clr sat drop_cnt", 64'(s_drop_cnt), 64'h0);
    chk("s6 clr frame_cnt", 64'(frame_cnt), 64'h0);
    udp_rx_dv = 1'b0; cnt_clr = 1'b0;
    tick();
    chk("s6 post-clr drop_cnt", 64'(drop_cnt), 64'h0);
    udp_rx_dv = 1'b1;
    tick();
    udp_rx_dv = 1'b0;
    tick();
    chk("s6 recount drop_cnt", 64'(drop_cnt), 64'd1);
    chk("s6 recount sat drop_cnt", 64'(s_drop_cnt), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
